// File: rtl/sb_pkg.sv
// ---------------------------------------------------------------------------
// sb_pkg -- shared definitions for the store buffer.
//   SB_DEPTH / SB_AW / SB_DW : default depth, address width and data width.
//   sb_entry_t               : one buffered store {valid, addr, data}.
// ---------------------------------------------------------------------------
package sb_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage : sb_pkg

// File: rtl/sb_match.sv
// ---------------------------------------------------------------------------
// sb_match -- youngest-match search over the store buffer entries.
//   entries : all buffer slots (valid, addr, data)
//   tail    : next write slot; the slot just below it is the youngest store
//   key     : load word address to compare against
//   hit     : some valid entry holds exactly key
//   idx     : slot of the youngest matching entry (meaningful when hit)
// ---------------------------------------------------------------------------
module sb_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PW-1:0]    tail,
  input  logic [SB_AW-1:0] key,
  output logic             hit,
  output logic [PW-1:0]    idx
);

  logic [PW-1:0] slot;
  logic          unused_data;

  // Walk from the oldest position (k = DEPTH) to the youngest (k = 1); a
  // later match overwrites an earlier one, so the youngest match wins.
  // NOTE: always_comb gives every output a default first so no latch forms.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      slot = tail - PW'(k);
      if (entries[slot].valid && (entries[slot].addr == key)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

  // The data field travels with the entry but is not part of the search.
  always_comb begin
    unused_data = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      unused_data = unused_data ^ (^entries[i].data);
    end
  end

endmodule : sb_match

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer -- in-order store FIFO in front of a single-port data memory.
// Stores are queued and drained to memory whenever the port is not needed by
// a load miss; loads that miss the buffer read memory with zero added latency.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   st_valid/st_addr/st_data   store request; st_ready = accepted this cycle
//   ld_valid/ld_addr           load request; ld_ready = completes this cycle
//   ld_data                    load result (valid with ld_valid & ld_ready)
//   mem_write/mem_read         data memory strobes (never both high)
//   mem_addr/mem_wdata         data memory address / write data
//   mem_rdata                  combinational memory read data
//   empty                      no stores buffered
//
// Build option: define STORE_BUFFER_FWD_EN to forward the youngest matching
// buffered store to a load. Without it, a matching load waits until the
// buffer has drained every matching store and then reads memory.
// ---------------------------------------------------------------------------
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_ready,
  output logic [DW-1:0] ld_data,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  // Entries are built on the package struct, so the widths must agree.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AW != SB_AW || DW != SB_DW)
  begin : g_bad_cfg
    $error("store_buffer: DEPTH must be a power of two >= 2; AW/DW must match sb_pkg");
  end

  logic [PW-1:0]  head, tail;
  logic [PW:0]    count;
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]  addr_q [DEPTH];
  logic [DW-1:0]  data_q [DEPTH];
  sb_entry_t      entries [DEPTH];

  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          ld_miss;
  logic          push;
  logic          drain;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = '{valid: valid_q[i], addr: addr_q[i], data: data_q[i]};
    end
  end

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries (entries),
    .tail    (tail),
    .key     (ld_addr),
    .hit     (hit),
    .idx     (hit_idx)
  );

  // Full-ness alone decides st_ready; a drain in the same cycle does not help.
  assign st_ready = rst_n && (count != FULL);
  assign empty    = (count == '0);
  assign push     = st_valid && st_ready;
  assign ld_miss  = rst_n && ld_valid && !hit;
  // The memory port belongs to a load miss first; otherwise the head drains.
  assign drain    = (count != '0) && !ld_miss;

  always_comb begin
    ld_ready  = 1'b0;
    ld_data   = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_miss) begin
      mem_read = 1'b1;
      mem_addr = ld_addr;
      ld_data  = mem_rdata;
      ld_ready = 1'b1;
    end else if (drain) begin
      mem_write = 1'b1;
      mem_addr  = entries[head].addr;
      mem_wdata = entries[head].data;
    end
`ifdef STORE_BUFFER_FWD_EN
    if (rst_n && ld_valid && hit) begin
      ld_ready = 1'b1;
      ld_data  = entries[hit_idx].data;
    end
`endif
  end

`ifndef STORE_BUFFER_FWD_EN
  // A matching load simply stalls, so the matched slot is not needed.
  logic unused_idx;
  assign unused_idx = ^hit_idx;
`endif

  // NOTE: control state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      // Push and drain never hit the same slot: equal pointers mean the
      // buffer is empty (no drain) or full (no push).
      if (drain) begin
        valid_q[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array is left out of reset; valid_q alone says which
  // slots hold live data, so clearing address/data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer -- directed bench for store_buffer (DEPTH=4, AW=DW=32).
// A small memory model returns 0x1000+addr for never-written words.
// ---------------------------------------------------------------------------
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        empty;

  int n_tests = 0;
  int n_fail  = 0;
  logic allow_overlap = 1'b0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  // Memory model.
  logic [31:0] mem_q [256];
  logic [255:0] written = '0;
  int wr_count = 0;

  assign mem_rdata = written[mem_addr[7:0]] ? mem_q[mem_addr[7:0]]
                                            : 32'h1000 + {24'h0, mem_addr[7:0]};

  always @(posedge clk) begin
    if (mem_write) begin
      mem_q[mem_addr[7:0]]   <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
      wr_count               <= wr_count + 1;
    end
  end

  // Store and load in one cycle is illegal; only the deliberate drain-stall
  // stimulus below is allowed to do it.
  always @(posedge clk) begin
    if (rst_n && !allow_overlap)
      assert (!(st_valid && ld_valid))
      else $error("illegal: st_valid and ld_valid both high");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sa, sd;
    logic        lv;
    logic [31:0] la;
    logic        e_st_ready, e_ld_ready;
    logic [31:0] e_ld_data;
    logic        e_mem_write, e_mem_read;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic        e_empty;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic lv, input logic [31:0] la,
                              input logic esr, input logic elr, input logic [31:0] eld,
                              input logic emw, input logic emr,
                              input logic [31:0] ema, input logic [31:0] emd,
                              input logic ee);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la;
    v.e_st_ready = esr; v.e_ld_ready = elr; v.e_ld_data = eld;
    v.e_mem_write = emw; v.e_mem_read = emr;
    v.e_mem_addr = ema; v.e_mem_wdata = emd; v.e_empty = ee;
    return v;
  endfunction

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " st_ready"},  st_ready,  v.e_st_ready);
    check({tag, " ld_ready"},  ld_ready,  v.e_ld_ready);
    check({tag, " ld_data"},   ld_data,   v.e_ld_data);
    check({tag, " mem_write"}, mem_write, v.e_mem_write);
    check({tag, " mem_read"},  mem_read,  v.e_mem_read);
    check({tag, " mem_addr"},  mem_addr,  v.e_mem_addr);
    check({tag, " mem_wdata"}, mem_wdata, v.e_mem_wdata);
    check({tag, " empty"},     empty,     v.e_empty);
  endtask

  vec_t vecs[$];
  int   wr_before;

  initial begin
    //              sv sa     sd      lv la  | st ld ld_data  mw mr maddr  mwdata  empty
    // Idle, then four plain stores drain in order 1..4.
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       0, 0, 0,     0,     1));
    vecs.push_back(mk(1, 1,     'h11,  0, 0,   1, 0, 0,       0, 0, 0,     0,     1));
    vecs.push_back(mk(1, 2,     'h22,  0, 0,   1, 0, 0,       1, 0, 1,     'h11,  0));
    vecs.push_back(mk(1, 3,     'h33,  0, 0,   1, 0, 0,       1, 0, 2,     'h22,  0));
    vecs.push_back(mk(1, 4,     'h44,  0, 0,   1, 0, 0,       1, 0, 3,     'h33,  0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       1, 0, 4,     'h44,  0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       0, 0, 0,     0,     1));
    // Two stores held by misses, then a lone miss at count 2: no drain.
    vecs.push_back(mk(1, 5,     'h55,  1, 9,   1, 1, 'h1009,  0, 1, 9,     0,     1));
    vecs.push_back(mk(1, 6,     'h66,  1, 9,   1, 1, 'h1009,  0, 1, 9,     0,     0));
    vecs.push_back(mk(0, 0,     0,     1, 9,   1, 1, 'h1009,  0, 1, 9,     0,     0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       1, 0, 5,     'h55,  0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       1, 0, 6,     'h66,  0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       0, 0, 0,     0,     1));
    // Fill to DEPTH while misses occupy the port; a fifth store is refused.
    vecs.push_back(mk(1, 10,    'hA0,  1, 9,   1, 1, 'h1009,  0, 1, 9,     0,     1));
    vecs.push_back(mk(1, 11,    'hA1,  1, 9,   1, 1, 'h1009,  0, 1, 9,     0,     0));
    vecs.push_back(mk(1, 12,    'hA2,  1, 9,   1, 1, 'h1009,  0, 1, 9,     0,     0));
    vecs.push_back(mk(1, 13,    'hA3,  1, 9,   1, 1, 'h1009,  0, 1, 9,     0,     0));
    vecs.push_back(mk(1, 14,    'hA4,  1, 9,   0, 1, 'h1009,  0, 1, 9,     0,     0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   0, 0, 0,       1, 0, 10,    'hA0,  0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       1, 0, 11,    'hA1,  0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       1, 0, 12,    'hA2,  0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       1, 0, 13,    'hA3,  0));
    vecs.push_back(mk(0, 0,     0,     0, 0,   1, 0, 0,       0, 0, 0,     0,     1));
    // AA then BB to addr 7 (both kept buffered), then load addr 7.
    vecs.push_back(mk(1, 7,     'hAA,  0, 0,   1, 0, 0,       0, 0, 0,     0,     1));
    vecs.push_back(mk(1, 7,     'hBB,  1, 9,   1, 1, 'h1009,  0, 1, 9,     0,     0));
`ifdef STORE_BUFFER_FWD_EN
    vecs.push_back(mk(0, 0,     0,     1, 7,   1, 1, 'hBB,    1, 0, 7,     'hAA,  0));
    vecs.push_back(mk(0, 0,     0,     1, 7,   1, 1, 'hBB,    1, 0, 7,     'hBB,  0));
`else
    vecs.push_back(mk(0, 0,     0,     1, 7,   1, 0, 0,       1, 0, 7,     'hAA,  0));
    vecs.push_back(mk(0, 0,     0,     1, 7,   1, 0, 0,       1, 0, 7,     'hBB,  0));
`endif
    vecs.push_back(mk(0, 0,     0,     1, 7,   1, 1, 'hBB,    0, 1, 7,     0,     1));

    // Outputs while reset is held, with both requests asserted.
    rst_n = 1'b0;
    drive(1, 3, 'h33, 1, 9);
    #12;
    check("rst st_ready",  st_ready,  1'b0);
    check("rst ld_ready",  ld_ready,  1'b0);
    check("rst mem_read",  mem_read,  1'b0);
    check("rst mem_write", mem_write, 1'b0);
    check("rst empty",     empty,     1'b1);
    check("rst ld_data",   ld_data,   32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;

    allow_overlap = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].lv, vecs[i].la);
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i]);
    end

    // Reset mid-drain with three stores buffered.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 32'(20 + k), 32'(32'hC0 + k), 1, 9);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    allow_overlap = 1'b0;
    #1;
    check("mid-drain mem_write", mem_write, 1'b1);
    check("mid-drain mem_addr",  mem_addr,  32'd20);
    wr_before = wr_count;
    #1 rst_n = 1'b0;
    #1;
    check("async rst mem_write", mem_write, 1'b0);
    check("async rst empty",     empty,     1'b1);
    check("async rst st_ready",  st_ready,  1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post-rst no writes",   wr_count,    wr_before);
    check("post-rst addr20 kept", written[20], 1'b0);
    check("post-rst empty",       empty,       1'b1);
    check("post-rst mem_write",   mem_write,   1'b0);
    check("post-rst mem_read",    mem_read,    1'b0);
    check("post-rst ld_ready",    ld_ready,    1'b0);
    check("post-rst ld_data",     ld_data,     32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_store_buffer
